hdmi_rd_ctrl: RTL and testbench

HDMI_RD_CTRL -- requirements
Module: hdmi_rd_ctrl

---
 rtl/hdmi_rd_ctrl.sv | 145 ++++++++++++++
 tb/tb_hdmi_rd_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_rd_ctrl.sv
// hdmi_rd_ctrl: display-side frame-buffer read controller.
// Sequences each video frame (IDLE/LOAD/ACTIVE/DONE). It reloads the read
// FIFO at frame start, streams pixels to the display driver, flips between
// frame-buffer banks when the writer has finished the other one, and flags
// frames that are cut short.
// Optional feature: define HDMI_RD_CTRL_UFLOW_CNT_EN to build the saturating
// underflow counter. Without it, uflow_cnt is tied to zero.
module hdmi_rd_ctrl (
  input  logic        hdmi_clk,
  input  logic        rst_n,
  input  logic        video_vs,
  input  logic        rd_en,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  output logic [15:0] rd_data,
  output logic        fifo_rd,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_q,
  output logic        rd_load,
  output logic        rd_bank,
  input  logic        wr_done,
  input  logic        wr_bank,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] uflow_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        vs_q, fs_q;
  logic [9:0]  ld_cnt_q;
  logic [21:0] pix_cnt_q, pix_nxt, total;
  logic        rd_vld_q, rd_load_q, rd_bank_q;
  logic        pend_q, pend_bank_q;
  logic        enter_load, done_hit;

  // Pixels expected in one frame. A zero dimension gives a zero total, so
  // ACTIVE finishes on its first cycle.
  assign total    = {11'd0, h_disp} * {11'd0, v_disp};
  assign pix_nxt  = pix_cnt_q + {21'd0, rd_en};
  assign done_hit = (pix_nxt >= total);

  // Frame start is the registered falling edge of video_vs.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      vs_q <= video_vs;
      fs_q <= vs_q & ~video_vs;
    end
  end

  // Next-state logic. A frame start that arrives mid-frame aborts the frame.
  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: if (fs_q) begin
        state_d    = LOAD;
        enter_load = 1'b1;
      end
      LOAD: if (!fifo_empty || ld_cnt_q == 10'h3FF) state_d = ACTIVE;
      ACTIVE: begin
        if (done_hit) state_d = DONE;
        else if (fs_q) begin
          frame_err  = 1'b1;
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, the LOAD timeout counter and the pixel counter.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_cnt_q  <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= (state_q == LOAD) ? ld_cnt_q + 10'd1 : 10'd0;
      if (enter_load || state_q == DONE) pix_cnt_q <= '0;
      else if (state_q == ACTIVE)        pix_cnt_q <= pix_nxt;
    end
  end

  // Bank handover. The reload uses the pending state from before this edge,
  // so a wr_done that lands on LOAD entry is held for the following frame.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_load_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
    end else begin
      rd_load_q <= enter_load;
      if (enter_load) begin
        if (pend_q) rd_bank_q <= pend_bank_q;
        pend_q <= 1'b0;
      end
      if (wr_done && (wr_bank != rd_bank_q)) begin
        pend_q      <= 1'b1;
        pend_bank_q <= wr_bank;
      end
    end
  end

  // The FIFO presents data one cycle after the strobe, so remember the strobe.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) rd_vld_q <= 1'b0;
    else        rd_vld_q <= fifo_rd;
  end

  assign fifo_rd    = (state_q == ACTIVE) & rd_en & ~fifo_empty;
  assign rd_data    = rd_vld_q ? fifo_q : 16'h0000;
  assign rd_load    = rd_load_q;
  assign rd_bank    = rd_bank_q;
  assign frame_done = (state_q == DONE);

`ifdef HDMI_RD_CTRL_UFLOW_CNT_EN
  logic [15:0] uflow_q;
  logic        uflow;

  assign uflow = rd_en & ((state_q != ACTIVE) | fifo_empty);

  // Saturating count of pixel requests that could not be served.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n)                              uflow_q <= '0;
    else if (uflow && uflow_q != 16'hFFFF)   uflow_q <= uflow_q + 16'd1;
  end

  assign uflow_cnt = uflow_q;
`else
  assign uflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hdmi_rd_ctrl.sv
// Directed bench for hdmi_rd_ctrl. Inputs change just after the falling edge,
// and outputs are sampled 1ns later.
module tb_hdmi_rd_ctrl;

`ifdef HDMI_RD_CTRL_UFLOW_CNT_EN
  localparam logic [15:0] EXP_UF5 = 16'd5;
`else
  localparam logic [15:0] EXP_UF5 = 16'd0;
`endif

  logic        hdmi_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_vs = 1'b0, rd_en = 1'b0, fifo_empty = 1'b0;
  logic        wr_done = 1'b0, wr_bank = 1'b0;
  logic [10:0] h_disp = 11'd8, v_disp = 11'd2;
  logic [15:0] fifo_q = 16'h0;
  logic [15:0] rd_data, uflow_cnt;
  logic        fifo_rd, rd_load, rd_bank, frame_done, frame_err;

  int n_chk = 0, n_pass = 0;
  int fd_cnt = 0, fe_cnt = 0, ld_cnt = 0, rd_cnt = 0;

  always #5 hdmi_clk = ~hdmi_clk;

  hdmi_rd_ctrl dut (
    .hdmi_clk(hdmi_clk), .rst_n(rst_n), .video_vs(video_vs), .rd_en(rd_en),
    .h_disp(h_disp), .v_disp(v_disp), .rd_data(rd_data), .fifo_rd(fifo_rd),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .rd_load(rd_load), .rd_bank(rd_bank),
    .wr_done(wr_done), .wr_bank(wr_bank), .frame_done(frame_done),
    .frame_err(frame_err), .uflow_cnt(uflow_cnt)
  );

  task automatic tick();
    #1;
    if (frame_done) fd_cnt++;
    if (frame_err)  fe_cnt++;
    if (rd_load)    ld_cnt++;
    if (fifo_rd)    rd_cnt++;
  endtask

  task automatic nxt();
    @(negedge hdmi_clk);
  endtask

  task automatic cyc();
    tick();
    nxt();
  endtask

  task automatic clr_cnts();
    fd_cnt = 0; fe_cnt = 0; ld_cnt = 0; rd_cnt = 0;
  endtask

  // Pulse video_vs. The reload pulse shows two cycles after the fall.
  task automatic begin_frame(input logic exp_bank, input logic wr_at_fs, input string nm);
    video_vs = 1'b1; cyc(); cyc();
    video_vs = 1'b0; cyc();
    if (wr_at_fs) begin wr_done = 1'b1; wr_bank = 1'b1; end
    cyc();
    wr_done = 1'b0;
    tick();
    n_chk++; if (rd_load !== 1'b1) $display("FAIL %s_rd_load: got %0b exp 1", nm, rd_load); else n_pass++;
    n_chk++; if (rd_bank !== exp_bank) $display("FAIL %s_rd_bank: got %0b exp %0b", nm, rd_bank, exp_bank); else n_pass++;
    nxt();
  endtask

  // n pixel requests with the FIFO non-empty, then one idle cycle.
  task automatic pixels(input int n, input logic [15:0] base, input logic exp_done, input string nm);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1; fifo_q = base + 16'(i);
      tick();
      n_chk++; if (fifo_rd !== 1'b1) $display("FAIL %s_fifo_rd[%0d]: got %0b exp 1", nm, i, fifo_rd); else n_pass++;
      n_chk++; if (rd_data !== ((i == 0) ? 16'h0 : fifo_q)) $display("FAIL %s_rd_data[%0d]: got %h exp %h", nm, i, rd_data, (i == 0) ? 16'h0 : fifo_q); else n_pass++;
      n_chk++; if (frame_done !== 1'b0) $display("FAIL %s_early_done[%0d]: got %0b exp 0", nm, i, frame_done); else n_pass++;
      nxt();
    end
    rd_en = 1'b0; fifo_q = base + 16'(n);
    tick();
    n_chk++; if (rd_data !== fifo_q) $display("FAIL %s_rd_data_last: got %h exp %h", nm, rd_data, fifo_q); else n_pass++;
    n_chk++; if (frame_done !== exp_done) $display("FAIL %s_frame_done: got %0b exp %0b", nm, frame_done, exp_done); else n_pass++;
    nxt();
  endtask

  task automatic test_reset();
    nxt(); tick();
    n_chk++; if (rd_data !== 16'h0) $display("FAIL rst_rd_data: got %h exp 0000", rd_data); else n_pass++;
    n_chk++; if ({fifo_rd, rd_load, rd_bank, frame_done, frame_err} !== 5'b0) $display("FAIL rst_bits: got %b exp 00000", {fifo_rd, rd_load, rd_bank, frame_done, frame_err}); else n_pass++;
    n_chk++; if (uflow_cnt !== 16'h0) $display("FAIL rst_uflow: got %0d exp 0", uflow_cnt); else n_pass++;
    nxt();
    rst_n = 1'b1; cyc(); cyc();
  endtask

  task automatic test_basic();
    clr_cnts();
    begin_frame(1'b0, 1'b0, "basic");
    pixels(16, 16'hA000, 1'b1, "basic");
    cyc();
    n_chk++; if (fd_cnt !== 1) $display("FAIL basic_done_cnt: got %0d exp 1", fd_cnt); else n_pass++;
    n_chk++; if (rd_cnt !== 16) $display("FAIL basic_rd_cnt: got %0d exp 16", rd_cnt); else n_pass++;
    n_chk++; if (fe_cnt !== 0) $display("FAIL basic_err_cnt: got %0d exp 0", fe_cnt); else n_pass++;
    n_chk++; if (uflow_cnt !== 16'h0) $display("FAIL basic_uflow: got %0d exp 0", uflow_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    clr_cnts();
    fifo_empty = 1'b1;
    begin_frame(1'b0, 1'b0, "tmo");
    for (int i = 0; i < 1023; i++) cyc();
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1; fifo_q = 16'h5A00 + 16'(i);
      tick();
      n_chk++; if (fifo_rd !== 1'b0) $display("FAIL tmo_fifo_rd[%0d]: got %0b exp 0", i, fifo_rd); else n_pass++;
      n_chk++; if (rd_data !== 16'h0) $display("FAIL tmo_rd_data[%0d]: got %h exp 0000", i, rd_data); else n_pass++;
      nxt();
    end
    rd_en = 1'b0; tick();
    n_chk++; if (uflow_cnt !== EXP_UF5) $display("FAIL tmo_uflow: got %0d exp %0d", uflow_cnt, EXP_UF5); else n_pass++;
    nxt();
    fifo_empty = 1'b0;
    pixels(11, 16'hB000, 1'b1, "tmo");
    cyc();
    n_chk++; if (fd_cnt !== 1) $display("FAIL tmo_done_cnt: got %0d exp 1", fd_cnt); else n_pass++;
    n_chk++; if (rd_cnt !== 11) $display("FAIL tmo_rd_cnt: got %0d exp 11", rd_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    clr_cnts();
    begin_frame(1'b0, 1'b0, "abort1");
    pixels(10, 16'hC000, 1'b0, "abort1");
    begin_frame(1'b0, 1'b0, "abort2");
    n_chk++; if (fe_cnt !== 1) $display("FAIL abort_err_cnt: got %0d exp 1", fe_cnt); else n_pass++;
    n_chk++; if (fd_cnt !== 0) $display("FAIL abort_no_done: got %0d exp 0", fd_cnt); else n_pass++;
    pixels(16, 16'hC100, 1'b1, "abort2");
    cyc();
    n_chk++; if (fd_cnt !== 1) $display("FAIL abort_done_cnt: got %0d exp 1", fd_cnt); else n_pass++;
    n_chk++; if (ld_cnt !== 2) $display("FAIL abort_load_cnt: got %0d exp 2", ld_cnt); else n_pass++;
  endtask

  task automatic test_bank_switch();
    begin_frame(1'b0, 1'b0, "bank1");
    pixels(5, 16'hD000, 1'b0, "bank1a");
    wr_done = 1'b1; wr_bank = 1'b1; tick();
    n_chk++; if (rd_bank !== 1'b0) $display("FAIL bank_hold: got %0b exp 0", rd_bank); else n_pass++;
    nxt(); wr_done = 1'b0;
    pixels(11, 16'hD100, 1'b1, "bank1b");
    begin_frame(1'b1, 1'b0, "bank2");
    pixels(3, 16'hD200, 1'b0, "bank2a");
    wr_done = 1'b1; wr_bank = 1'b1; cyc(); wr_done = 1'b0;
    pixels(13, 16'hD300, 1'b1, "bank2b");
    begin_frame(1'b1, 1'b0, "bank3");
    pixels(16, 16'hD400, 1'b1, "bank3");
  endtask

  task automatic test_reset_mid();
    begin_frame(1'b1, 1'b0, "rmid");
    pixels(4, 16'hE000, 1'b0, "rmid");
    clr_cnts();
    rst_n = 1'b0; rd_en = 1'b1; tick();
    n_chk++; if ({fifo_rd, rd_load, rd_bank, frame_done, frame_err} !== 5'b0) $display("FAIL rmid_bits: got %b exp 00000", {fifo_rd, rd_load, rd_bank, frame_done, frame_err}); else n_pass++;
    n_chk++; if (uflow_cnt !== 16'h0) $display("FAIL rmid_uflow: got %0d exp 0", uflow_cnt); else n_pass++;
    nxt();
    rst_n = 1'b1; rd_en = 1'b0; cyc(); cyc(); cyc();
    begin_frame(1'b0, 1'b0, "rmid_fs");
    n_chk++; if (fd_cnt + fe_cnt !== 0) $display("FAIL rmid_stray: got %0d exp 0", fd_cnt + fe_cnt); else n_pass++;
    n_chk++; if (ld_cnt !== 1) $display("FAIL rmid_load_cnt: got %0d exp 1", ld_cnt); else n_pass++;
    n_chk++; if (uflow_cnt !== 16'h0) $display("FAIL rmid_uflow2: got %0d exp 0", uflow_cnt); else n_pass++;
    pixels(16, 16'hE100, 1'b1, "rmid2");
  endtask

  task automatic test_back_to_back();
    begin_frame(1'b0, 1'b1, "coinc1");
    pixels(16, 16'hF000, 1'b1, "coinc1");
    begin_frame(1'b1, 1'b0, "coinc2");
    pixels(16, 16'hF100, 1'b1, "coinc2");
  endtask

  task automatic test_zero_size();
    h_disp = 11'd0;
    begin_frame(1'b1, 1'b0, "zero");
    tick();
    n_chk++; if (frame_done !== 1'b0) $display("FAIL zero_active: got %0b exp 0", frame_done); else n_pass++;
    nxt(); tick();
    n_chk++; if (frame_done !== 1'b1) $display("FAIL zero_done: got %0b exp 1", frame_done); else n_pass++;
    nxt(); tick();
    n_chk++; if (frame_done !== 1'b0) $display("FAIL zero_after: got %0b exp 0", frame_done); else n_pass++;
    nxt();
    h_disp = 11'd8;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_abort();
    test_bank_switch();
    test_reset_mid();
    test_back_to_back();
    test_zero_size();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
